// File: rtl/truth_table_checker.sv
// Response checker for an exhaustive input sweep: compares each strobed DUT output
// against a fixed truth table, tracks vector coverage, counts and captures mismatches.
module truth_table_checker #(
  parameter int                      N_IN      = 4,
  parameter logic [(2**N_IN)-1:0]    EXP_TABLE = 16'hB5C3,
  parameter int                      ERR_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sample_stb,
  input  logic [N_IN-1:0]        vec,
  input  logic                   f,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [(2**N_IN)-1:0]   cov_map,
  output logic                   first_fail_v,
  output logic [N_IN-1:0]        first_fail
);

  localparam int N_VEC = 2**N_IN;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ERR_W-1:0]  err_reg;
  logic [N_VEC-1:0]  cov_reg;
  logic [N_VEC-1:0]  vec_hit;
  logic [N_VEC-1:0]  cov_next;
  logic              ffv_reg;
  logic [N_IN-1:0]   ff_reg;
  logic              accept;
  logic              mismatch;

  // start wins over a same-edge strobe, so the sample is dropped
  assign accept   = (state_reg == ACTIVE) && sample_stb && !start;
  assign mismatch = accept && (f != EXP_TABLE[vec]);

  genvar gi;
  generate
    for (gi = 0; gi < N_VEC; gi++) begin : g_hit
      assign vec_hit[gi] = accept && (32'(vec) == gi);
    end
  endgenerate

  assign cov_next = cov_reg | vec_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      err_reg   <= '0;
      cov_reg   <= '0;
      ffv_reg   <= 1'b0;
      ff_reg    <= '0;
    end else if (start) begin
      state_reg <= ACTIVE;
      err_reg   <= '0;
      cov_reg   <= '0;
      ffv_reg   <= 1'b0;
      ff_reg    <= '0;
    end else if (accept) begin
      cov_reg <= cov_next;
      if (mismatch) begin
        if (err_reg != ERR_MAX) begin
          err_reg <= err_reg + ERR_W'(1);
        end
        if (!ffv_reg) begin
          ffv_reg <= 1'b1;
          ff_reg  <= vec;
        end
      end
      if (&cov_next) begin
        state_reg <= DONE;
      end
    end
  end

  assign busy         = (state_reg == ACTIVE);
  assign done         = (state_reg == DONE);
  assign pass         = done && (err_reg == '0);
  assign err_count    = err_reg;
  assign cov_map      = cov_reg;
  assign first_fail_v = ffv_reg;
  assign first_fail   = ff_reg;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed and randomized checks of truth_table_checker against a behavioural model
// built from the coverage/mismatch rules; a second instance exercises a 2-bit error counter.
module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, sample_stb = 1'b0, f = 1'b0;
  logic [3:0]  vec = '0;
  logic        busy, done, pass, first_fail_v;
  logic [7:0]  err_count;
  logic [15:0] cov_map;
  logic [3:0]  first_fail;

  logic        start2 = 1'b0, stb2 = 1'b0, f2 = 1'b0;
  logic [3:0]  vec2 = '0;
  logic        busy2, done2, pass2, ffv2;
  logic [1:0]  err2;
  logic [15:0] cov2;
  logic [3:0]  ff2;

  truth_table_checker #(.N_IN(4), .EXP_TABLE(16'hB5C3), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_stb(sample_stb), .vec(vec), .f(f),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .cov_map(cov_map),
    .first_fail_v(first_fail_v), .first_fail(first_fail)
  );

  truth_table_checker #(.N_IN(4), .EXP_TABLE(16'hB5C3), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sample_stb(stb2), .vec(vec2), .f(f2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .cov_map(cov2),
    .first_fail_v(ffv2), .first_fail(ff2)
  );

  int checks = 0;
  int errors = 0;

  // reference model: 0 = idle, 1 = active, 2 = done
  int m_state = 0;
  bit m_cov[16];
  int m_err = 0;
  bit m_ffv = 0;
  int m_ff  = 0;

  function automatic bit exp_f(input int v);
    logic [15:0] t;
    t = 16'hB5C3;
    return t[v];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    foreach (m_cov[i]) m_cov[i] = 1'b0;
    m_err = 0;
    m_ffv = 0;
    m_ff  = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit stb, input int v, input bit fv);
    int n;
    if (r) begin
      model_clear();
      m_state = 0;
    end else if (s) begin
      model_clear();
      m_state = 1;
    end else if (m_state == 1 && stb) begin
      m_cov[v] = 1'b1;
      if (fv != exp_f(v)) begin
        if (m_err < 255) m_err++;
        if (!m_ffv) begin
          m_ffv = 1;
          m_ff  = v;
        end
      end
      n = 0;
      foreach (m_cov[i]) if (m_cov[i]) n++;
      if (n == 16) m_state = 2;
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] ec;
    for (int i = 0; i < 16; i++) ec[i] = m_cov[i];
    check({tag, ".busy"}, 32'(busy), 32'(m_state == 1));
    check({tag, ".done"}, 32'(done), 32'(m_state == 2));
    check({tag, ".pass"}, 32'(pass), 32'(m_state == 2 && m_err == 0));
    check({tag, ".err"},  32'(err_count), 32'(m_err));
    check({tag, ".cov"},  32'(cov_map), 32'(ec));
    check({tag, ".ffv"},  32'(first_fail_v), 32'(m_ffv));
    check({tag, ".ff"},   32'(first_fail), 32'(m_ff));
  endtask

  task automatic apply(input string tag, input bit r, input bit s, input bit stb,
                       input int v, input bit fv);
    @(negedge clk);
    rst = r; start = s; sample_stb = stb; vec = v[3:0]; f = fv;
    @(posedge clk);
    model_step(r, s, stb, v, fv);
    #1;
    check_all(tag);
    $display("%s: rst=%0b start=%0b stb=%0b vec=%0d f=%0b -> busy=%0b done=%0b pass=%0b err=%0d cov=%h",
             tag, r, s, stb, v, fv, busy, done, pass, err_count, cov_map);
  endtask

  initial begin
    // reset and reset-state check
    apply("reset", 1, 0, 0, 0, 0);
    apply("idle_stb", 0, 0, 1, 4, 0);

    // 1: clean sweep
    apply("t1_start", 0, 1, 0, 0, 0);
    for (int v = 0; v < 16; v++) apply("t1", 0, 0, 1, v, exp_f(v));
    check("t1_done", 32'(done), 32'd1);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_cov", 32'(cov_map), 32'hFFFF);

    // 2: mismatches at 5 and 9
    apply("t2_start", 0, 1, 0, 0, 0);
    for (int v = 0; v < 16; v++) apply("t2", 0, 0, 1, v, exp_f(v) ^ (v == 5 || v == 9));
    check("t2_err", 32'(err_count), 32'd2);
    check("t2_ff", 32'(first_fail), 32'd5);
    check("t2_pass", 32'(pass), 32'd0);

    // 3: repeated wrong vector before the last one
    apply("t3_start", 0, 1, 0, 0, 0);
    for (int v = 0; v < 15; v++) apply("t3", 0, 0, 1, v, exp_f(v));
    apply("t3_rep", 0, 0, 1, 3, !exp_f(3));
    apply("t3_rep", 0, 0, 1, 3, !exp_f(3));
    check("t3_cov_pre", 32'(cov_map), 32'h7FFF);
    check("t3_done_pre", 32'(done), 32'd0);
    apply("t3_last", 0, 0, 1, 15, exp_f(15));
    check("t3_cov", 32'(cov_map), 32'hFFFF);
    check("t3_err", 32'(err_count), 32'd2);
    check("t3_ff", 32'(first_fail), 32'd3);

    // 4: 2-bit counter saturation on the second instance
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; stb2 = 1'b1; vec2 = 4'd0; f2 = !exp_f(0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("t4_err", 32'(err2), 32'(k < 3 ? k : 3));
      $display("t4: wrong strobe %0d on vec 0 -> err=%0d cov=%h done=%0b", k, err2, cov2, done2);
    end
    @(negedge clk); stb2 = 1'b0;
    check("t4_done", 32'(done2), 32'd0);
    check("t4_cov", 32'(cov2), 32'h0001);
    check("t4_ffv", 32'(ffv2), 32'd1);

    // 5: reset in the middle of a run
    apply("t5_start", 0, 1, 0, 0, 0);
    for (int v = 0; v < 7; v++) apply("t5", 0, 0, 1, v, (v == 2) ? !exp_f(v) : exp_f(v));
    apply("t5_rst", 1, 0, 1, 7, 0);
    check("t5_cov", 32'(cov_map), 32'd0);
    for (int v = 7; v < 10; v++) apply("t5_ign", 0, 0, 1, v, !exp_f(v));
    check("t5_err", 32'(err_count), 32'd0);

    // 6: start with a same-edge strobe, then strobes in DONE
    apply("t6_start", 0, 1, 1, 6, !exp_f(6));
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_cov", 32'(cov_map), 32'd0);
    for (int v = 15; v >= 0; v--) apply("t6", 0, 0, 1, v, exp_f(v) ^ (v == 12));
    for (int k = 0; k < 3; k++) apply("t6_done", 0, 0, 1, k, !exp_f(k));
    check("t6_err", 32'(err_count), 32'd1);
    check("t6_pass", 32'(pass), 32'd0);

    // randomized run against the model
    for (int n = 0; n < 400; n++) begin
      apply("rand", ($urandom % 80) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
            int'($urandom % 16), 1'b0 ^ (($urandom % 8) == 0) ^ exp_f(0) ^ exp_f(0));
    end
    // use the model's expected bit for mostly-correct random f
    for (int n = 0; n < 400; n++) begin
      int v;
      v = int'($urandom % 16);
      apply("rand2", ($urandom % 100) == 0, ($urandom % 50) == 0, ($urandom % 4) != 0,
            v, exp_f(v) ^ (($urandom % 10) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
